// File: rtl/irigb_tx_encoder.sv
// IRIG-B DC level-shift frame encoder.
// A pps_in strobe (with tx_en high) latches the time fields and starts a
// 100-bit frame. Each bit lasts BIT_CYC clocks and is high for W0 ('0'),
// W1 ('1') or WP (marker) clocks at its start.
// Optional feature macro: IRIGB_TX_SBS_EN -- when defined, straight-binary
// seconds of day go out on bits 80-88 and 90-97; otherwise those bits are 0.
module irigb_tx_encoder #(
    parameter int CLK_FREQ_HZ = 125000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        pps_in,
    input  logic [6:0]  bcd_sec,
    input  logic [6:0]  bcd_min,
    input  logic [5:0]  bcd_hour,
    input  logic [9:0]  bcd_day,
    input  logic [7:0]  bcd_year,
    input  logic [16:0] sbs_sec,
    output logic        irigb_out,
    output logic        frame_start,
    output logic [6:0]  bit_idx,
    output logic        busy
);

    localparam int BIT_CYC = CLK_FREQ_HZ / 100;
    localparam int W0      = CLK_FREQ_HZ / 500;
    localparam int W1      = CLK_FREQ_HZ / 200;
    localparam int WP      = (CLK_FREQ_HZ / 1000) * 8;
    localparam int CW      = $clog2(BIT_CYC);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_bit;
    logic          r_out;
    logic          r_fs;
    logic [6:0]    r_sec;
    logic [6:0]    r_min;
    logic [5:0]    r_hour;
    logic [9:0]    r_day;
    logic [7:0]    r_year;
`ifdef IRIGB_TX_SBS_EN
    logic [16:0]   r_sbs;
`else
    logic          w_unused_sbs;
    assign w_unused_sbs = ^sbs_sec;
`endif

    logic [99:0]   w_frame;
    logic          w_marker;
    int            w_width;
    int            w_cnt_nxt;
    logic          w_last;

    // Data bit value for every frame position, built from the latched fields
    always_comb begin
        w_frame        = '0;
        w_frame[4:1]   = r_sec[3:0];
        w_frame[8:6]   = r_sec[6:4];
        w_frame[13:10] = r_min[3:0];
        w_frame[17:15] = r_min[6:4];
        w_frame[23:20] = r_hour[3:0];
        w_frame[26:25] = r_hour[5:4];
        w_frame[33:30] = r_day[3:0];
        w_frame[38:35] = r_day[7:4];
        w_frame[41:40] = r_day[9:8];
        w_frame[53:50] = r_year[3:0];
        w_frame[58:55] = r_year[7:4];
`ifdef IRIGB_TX_SBS_EN
        w_frame[88:80] = r_sbs[8:0];
        w_frame[97:90] = r_sbs[16:9];
`endif
    end

    // High-time width of the bit currently on the line
    always_comb begin
        w_marker  = (r_bit == 7'd0) || ((r_bit % 7'd10) == 7'd9);
        w_width   = w_marker ? WP : (w_frame[r_bit] ? W1 : W0);
        w_cnt_nxt = int'(r_cnt) + 1;
        w_last    = (r_cnt == CW'(BIT_CYC - 1));
    end

    // Frame sequencer; output level is computed for the next cycle so it is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_out   <= 1'b0;
            r_fs    <= 1'b0;
            r_sec   <= '0;
            r_min   <= '0;
            r_hour  <= '0;
            r_day   <= '0;
            r_year  <= '0;
`ifdef IRIGB_TX_SBS_EN
            r_sbs   <= '0;
`endif
        end else if (!tx_en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_out   <= 1'b0;
            r_fs    <= 1'b0;
        end else if (pps_in) begin
            // Start or resync: bit 0 is a marker, so the line goes high now
            r_state <= SEND;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_out   <= 1'b1;
            r_fs    <= 1'b1;
            r_sec   <= bcd_sec;
            r_min   <= bcd_min;
            r_hour  <= bcd_hour;
            r_day   <= bcd_day;
            r_year  <= bcd_year;
`ifdef IRIGB_TX_SBS_EN
            r_sbs   <= sbs_sec;
`endif
        end else begin
            r_fs <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out <= 1'b0;
                end
                SEND: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_bit == 7'd99) begin
                            r_state <= IDLE;
                            r_bit   <= '0;
                            r_out   <= 1'b0;
                        end else begin
                            // every width is nonzero, so each bit opens high
                            r_bit <= r_bit + 7'd1;
                            r_out <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_out <= (w_cnt_nxt < w_width);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign irigb_out   = r_out;
    assign frame_start = r_fs;
    assign bit_idx     = r_bit;
    assign busy        = (r_state == SEND);

endmodule

// File: tb/tb_irigb_tx_encoder.sv
// Self-checking bench for irigb_tx_encoder at a reduced clock rate so whole
// frames fit in a short run: CLK_FREQ_HZ=5000 -> BIT_CYC=50, W0=10, W1=25, WP=40.
// Expected waveform comes from a frame-level model: a 100-entry bit table
// filled from the latched field values, then level = (offset within bit < width).
module tb_irigb_tx_encoder;

    localparam int FREQ  = 5000;
    localparam int BIT   = FREQ / 100;
    localparam int W0    = FREQ / 500;
    localparam int W1    = FREQ / 200;
    localparam int WP    = FREQ * 8 / 1000;
    localparam int FRAME = 100 * BIT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b0;
    logic        pps_in = 1'b0;
    logic [6:0]  bcd_sec = '0;
    logic [6:0]  bcd_min = '0;
    logic [5:0]  bcd_hour = '0;
    logic [9:0]  bcd_day = '0;
    logic [7:0]  bcd_year = '0;
    logic [16:0] sbs_sec = '0;
    logic        irigb_out;
    logic        frame_start;
    logic [6:0]  bit_idx;
    logic        busy;

    irigb_tx_encoder #(.CLK_FREQ_HZ(FREQ)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .pps_in(pps_in),
        .bcd_sec(bcd_sec), .bcd_min(bcd_min), .bcd_hour(bcd_hour),
        .bcd_day(bcd_day), .bcd_year(bcd_year), .sbs_sec(sbs_sec),
        .irigb_out(irigb_out), .frame_start(frame_start),
        .bit_idx(bit_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_bits [100];
    int off = 0;
    bit active = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic put(input int v, input int start, input int len);
        for (int i = 0; i < len; i++) exp_bits[start + i] = (v >> i) & 1;
    endtask

    task automatic load_model(input int sec, input int mn, input int hr,
                              input int day, input int yr, input int sbs);
        for (int i = 0; i < 100; i++) exp_bits[i] = 0;
        put(sec, 1, 4);       put(sec >> 4, 6, 3);
        put(mn, 10, 4);       put(mn >> 4, 15, 3);
        put(hr, 20, 4);       put(hr >> 4, 25, 2);
        put(day, 30, 4);      put(day >> 4, 35, 4);  put(day >> 8, 40, 2);
        put(yr, 50, 4);       put(yr >> 4, 55, 4);
`ifdef IRIGB_TX_SBS_EN
        put(sbs, 80, 9);      put(sbs >> 9, 90, 8);
`else
        if (sbs < 0) put(sbs, 80, 0);
`endif
    endtask

    function automatic int exp_w(input int b);
        if (b == 0 || b % 10 == 9) return WP;
        return (exp_bits[b] != 0) ? W1 : W0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model for the current offset
    task automatic check_cycle();
        int e_out, e_busy, e_idx, e_fs, b, p;
        if (active && off < FRAME) begin
            b = off / BIT;
            p = off % BIT;
            e_out = (p < exp_w(b)) ? 1 : 0;
            e_busy = 1; e_idx = b; e_fs = (off == 0) ? 1 : 0;
        end else begin
            e_out = 0; e_busy = 0; e_idx = 0; e_fs = 0;
        end
        chk($sformatf("out@%0d", off), int'(irigb_out), e_out);
        chk($sformatf("busy@%0d", off), int'(busy), e_busy);
        chk($sformatf("bit_idx@%0d", off), int'(bit_idx), e_idx);
        chk($sformatf("frame_start@%0d", off), int'(frame_start), e_fs);
    endtask

    // Time inputs change freely between strobes; only the pps cycle matters
    task automatic scramble();
        bcd_sec  = 7'($urandom);
        bcd_min  = 7'($urandom);
        bcd_hour = 6'($urandom);
        bcd_day  = 10'($urandom);
        bcd_year = 8'($urandom);
        sbs_sec  = 17'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle();
            scramble();
            tick();
            off++;
        end
    endtask

    // Present values with a pps strobe; current cycle must already be checked
    task automatic fire(input int sec, input int mn, input int hr,
                        input int day, input int yr, input int sbs);
        bcd_sec = 7'(sec); bcd_min = 7'(mn); bcd_hour = 6'(hr);
        bcd_day = 10'(day); bcd_year = 8'(yr); sbs_sec = 17'(sbs);
        pps_in = 1'b1;
        load_model(sec & 'h7f, mn & 'h7f, hr & 'h3f, day & 'h3ff, yr & 'hff, sbs & 'h1ffff);
        tick();
        pps_in = 1'b0;
        off = 0;
        active = 1'b1;
    endtask

    task automatic fire_rand();
        fire(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 131071)));
    endtask

    initial begin
        // Reset state, checked while reset is still asserted
        repeat (3) tick();
        chk("rst_out", int'(irigb_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(bit_idx), 0);
        chk("rst_fs", int'(frame_start), 0);
        rst = 1'b0;
        tx_en = 1'b1;
        tick();
        run(5);

        // Directed frame, then run past the end: busy drops, line stays low
        check_cycle();
        fire('h59, 'h34, 'h12, 'h123, 'h24, 45299);
        run(FRAME + 10);

        // Frame ending exactly as the next pps arrives: no gap cycle
        check_cycle();
        fire_rand();
        run(FRAME - 1);
        check_cycle();
        fire_rand();

        // Resync at bit 40, cycle 15
        run(40 * BIT + 15);
        check_cycle();
        fire_rand();
        run(200);

        // tx_en dropped mid-frame: idle from the next edge, pps ignored
        check_cycle();
        tx_en = 1'b0;
        tick();
        active = 1'b0;
        off++;
        run(3);
        pps_in = 1'b1;
        check_cycle();
        tick();
        pps_in = 1'b0;
        run(10);
        tx_en = 1'b1;
        run(3);

        // Async reset mid-bit clears outputs without waiting for an edge
        check_cycle();
        fire_rand();
        run(1234);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", int'(irigb_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_idx", int'(bit_idx), 0);
        tick();
        rst = 1'b0;
        active = 1'b0;
        run(5);

        // Random contiguous frames
        for (int f = 0; f < 3; f++) begin
            check_cycle();
            fire_rand();
            run(FRAME - 1);
        end
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irigb_tx_encoder.md
IRIGB_TX_ENCODER -- requirements
Module: irigb_tx_encoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 125000000, clock frequency in Hz; it SHALL be an exact multiple of 1000.
REQ-002 SHALL have port clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tx_en  input  1  transmit enable, level.
REQ-005 SHALL have port pps_in  input  1  one-cycle, clk-synchronous frame-start strobe marking the on-time point.
REQ-006 SHALL have port bcd_sec  input  7  seconds, BCD 00-59.
REQ-007 SHALL have port bcd_min  input  7  minutes, BCD 00-59.
REQ-008 SHALL have port bcd_hour  input  6  hours, BCD 00-23.
REQ-009 SHALL have port bcd_day  input  10  day of year, BCD 001-366.
REQ-010 SHALL have port bcd_year  input  8  year, BCD 00-99.
REQ-011 SHALL have port sbs_sec  input  17  straight-binary seconds of day, 0-86399.
REQ-012 SHALL have port irigb_out  output  1  IRIG-B DC level-shift serial output.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at the first cycle of bit 0.
REQ-014 SHALL have port bit_idx  output  7  index of the bit being sent, 0-99.
REQ-015 SHALL have port busy  output  1  high while a frame is being transmitted.

Function
REQ-016 SHALL derive BIT_CYC=CLK_FREQ_HZ/100, W0=CLK_FREQ_HZ/500, W1=CLK_FREQ_HZ/200 and WP=CLK_FREQ_HZ*8/1000 as cycle counts.
REQ-017 SHALL implement two states: IDLE (irigb_out=0, busy=0) and SEND (busy=1).
REQ-018 SHALL, in either state, on a cycle with pps_in=1 and tx_en=1, latch all time inputs, enter SEND with bit_idx=0 and cycle counter=0, and pulse frame_start in the next cycle.
REQ-019 SHALL drive irigb_out high starting one cycle after the pps_in cycle (latency 1); it SHALL remain high for exactly WP cycles on bit 0.
REQ-020 SHALL, for each bit, drive irigb_out high for the first W (W0 for '0', W1 for '1', WP for a marker) cycles of the BIT_CYC cycles and low for the rest.
REQ-021 SHALL place markers at bits 0, 9, 19, 29, 39, 49, 59, 69, 79, 89 and 99.
REQ-022 SHALL map latched values LSB first: sec units 1-4, sec tens 6-8, min units 10-13, min tens 15-17, hour units 20-23, hour tens 25-26, day units 30-33, day tens 35-38, day hundreds 40-41, year units 50-53, year tens 55-58; all other non-marker bits 0 except where REQ-030 applies.
REQ-023 SHALL increment bit_idx when the cycle counter reaches BIT_CYC-1, and SHALL reset the counter to 0 at that point.
REQ-024 SHALL return to IDLE after the last cycle of bit 99 if pps_in has not arrived, with irigb_out=0 and bit_idx held at 0.
REQ-025 SHALL treat pps_in arriving mid-frame (any bit, any cycle) as a resync: the current bit is abandoned and bit 0 restarts per REQ-018.
REQ-026 SHALL, when pps_in coincides with the last cycle of bit 99, start the new frame with no gap cycle.
REQ-027 SHALL, while tx_en=0, force IDLE on the next edge and ignore pps_in.
REQ-028 SHALL encode input values as given, with no BCD range checking; time inputs are sampled only on the pps_in cycle.

Reset
REQ-029 SHALL, while rst=1, asynchronously force IDLE with irigb_out=0, frame_start=0, bit_idx=0, busy=0, counters=0 and latched time=0.

Configuration
REQ-030 SHALL, when macro IRIGB_TX_SBS_EN is defined, send latched sbs_sec bits 0-8 on bits 80-88 and bits 9-16 on bits 90-97, LSB first; when the macro is undefined, SHALL send 0 on those bits and ignore sbs_sec.

Verification (CLK_FREQ_HZ=100000: BIT_CYC=1000, W0=200, W1=500, WP=800)
REQ-031 SHALL cover: pps_in with sec=0x59, min=0x34, hour=0x12, day=0x123, year=0x24 -> high widths: bit 0 800; bits 1-4 500,200,200,500; bits 6-8 500,200,500; bit 9 800; bits 40-41 500,200.
REQ-032 SHALL cover: pps_in every 100000 cycles -> contiguous frames, bits 99 and 0 both 800-cycle highs, frame_start once per frame.
REQ-033 SHALL cover: single pps_in with no follow-up -> busy falls after cycle 99999, irigb_out stays 0.
REQ-034 SHALL cover: pps_in at bit_idx=40, cycle 300 -> next cycle bit_idx=0, irigb_out high 800 cycles.
REQ-035 SHALL cover: rst mid-bit and tx_en=0 mid-frame -> irigb_out=0 and busy=0 (immediately for rst, next edge for tx_en); pps_in while tx_en=0 ignored.
REQ-036 SHALL cover: sbs_sec=45299 -> with IRIGB_TX_SBS_EN bits 80-88 send 0x0F3 LSB first and bits 90-97 send 0x58; without the macro those bits send 0.
